trap_csr_unit: RTL
==================

# trap_csr_unit

Parametrised machine-mode trap and CSR unit for the 5-stage pipelined RV32 core. It replaces the single-cause SCAUSE/SEPC logic with a full set of trap CSRs: mstatus, mie, mip, mtvec, mepc and mcause. It supports NUM_IRQ maskable interrupt lines, direct or vectored trap entry, MRET return, and CSRRW/CSRRS/CSRRC access. It sits beside the EX stage; its redirect outputs drive the NPC mux and the IF/ID and ID/EX flush.

## Interface
- XLEN, 32: data/address width.
- NUM_IRQ, 4: external interrupt lines, legal range 1..16.
- TVEC_RESET, 32'h0000_0100: reset value of mtvec.

- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- irq_in  in  NUM_IRQ  asynchronous level interrupt requests.
- ex_valid  in  1  EX holds a real instruction (not a bubble).
- ex_pc  in  XLEN  PC of the EX instruction.
- ex_exc  in  1  EX instruction raises a synchronous exception.
- ex_exc_code  in  8  exception cause code.
- ex_mret  in  1  EX instruction is MRET.
- csr_op  in  2  00 none, 01 RW, 10 RS, 11 RC.
- csr_addr  in  12  CSR address.
- csr_wdata  in  XLEN  rs1 value, already forwarded.
- csr_rdata  out  XLEN  old CSR value, combinational.
- redirect  out  1  pipeline redirect/flush this cycle.
- redirect_pc  out  XLEN  fetch target when redirect=1.
- irq_pending  out  NUM_IRQ  synchronized irq AND mie.

## Operation
- **CSR map.** Unmapped addresses read 0; writes to them are ignored.
  - mstatus 0x300: only MIE[3] and MPIE[7] are implemented; all other bits read 0.
  - mie 0x304: bits [NUM_IRQ-1:0] are implemented.
  - mip 0x344: read-only; returns the synchronized irq bits.
  - mtvec 0x305: bit1 reads 0; bit0 is MODE (0 direct, 1 vectored).
  - mepc 0x341: bits[1:0] read 0.
  - mcause 0x342: bit XLEN-1 is the interrupt flag; bits[7:0] hold the code.
- **Interrupt synchronizer.** irq_in passes through a 2-flop synchronizer per line.
  - pend = sync & mie.
  - irq_take = ex_valid & MIE & |pend.
  - The lowest-index pending line wins.
- **Priority per cycle** (only when ex_valid=1):
  1. Interrupt.
  2. ex_exc.
  3. ex_mret.
  4. CSR write.
  - A higher-priority event suppresses all lower ones: no CSR write and no MRET effect.
- **Trap entry (interrupt or exception).**
  - redirect=1.
  - On the next posedge:
    - mepc <= ex_pc. The faulting or interrupted instruction is not retired; software adds 4 for ECALL.
    - mcause <= {1, code=irq index} for an interrupt, or {0, ex_exc_code} for an exception.
    - MPIE <= MIE; MIE <= 0.
- **Trap target.**
  - Direct mode: mtvec base.
  - Vectored mode, interrupt: base + 4*index.
  - Exceptions always go to the base address.
- **MRET.**
  - redirect=1, redirect_pc = mepc.
  - On the next posedge: MIE <= MPIE; MPIE <= 1.
- **CSR write, applied at the posedge.**
  - RW: new = wdata.
  - RS: new = old | wdata.
  - RC: new = old & ~wdata.
  - RS/RC with wdata=0 performs no write.
  - Masking of unimplemented and read-only bits is applied after the op.
- csr_rdata always reflects the pre-write value at csr_addr, regardless of priority.
- When ex_valid=0: redirect=0 and no state changes, except the synchronizer.

## Timing
- redirect, redirect_pc and csr_rdata are combinational from the current inputs and state.
- All CSR updates occur at the posedge following the decision cycle.
- Interrupt latency: irq_in rising edge to pend visible takes 2 posedges. The redirect is raised in the first later cycle with ex_valid=1 and MIE=1.
- A CSR write that sets MIE takes effect for the following cycle's instruction, never the same cycle.
- Reset values:
  - mstatus 0, mie 0, mepc 0, mcause 0, mtvec TVEC_RESET, synchronizer 0.
  - redirect 0, irq_pending 0.
- Reset mid-trap cancels any pending update; the state is the reset values at reset deassertion.
- An irq deasserted before it is taken is lost; irq lines are level-held by the source.
- MRET with MIE=0 and pend≠0: MRET proceeds. The interrupt is taken on the next valid instruction after MIE becomes 1.

## Test plan
- Reset, then csr_op=RS, csr_addr=0x305, csr_wdata=0 -> csr_rdata=0x100; mstatus reads 0; redirect=0.
- CSRRS 0x300 with wdata=0x8 -> csr_rdata=0 that cycle; the next read returns 0x8.
- With MIE=1, ex_exc=1, code=0x0B, ex_pc=0x40, mtvec=0x100 -> redirect=1, target 0x100. Afterwards: mepc=0x40, mcause=0x0B, mstatus=0x80.
- irq_in[2]=1, mie=0x4, MIE=1, mtvec=0x201 -> irq_pending=0x4 after 2 clocks. On the next valid cycle with ex_pc=0x80: redirect target 0x208; afterwards mcause=0x80000002, mepc=0x80.
- Interrupt, ex_exc and a CSRRW to mie all in the same cycle -> the interrupt wins; mcause has its interrupt flag set; mie is unchanged.
- After the exception scenario, ex_mret=1 -> redirect_pc=0x40; afterwards mstatus=0x88. With ex_valid=0 and ex_mret=1 -> redirect=0 and no change.

Source files
------------

// File: rtl/trap_csr_unit.sv
// rtl/trap_csr_unit.sv - machine-mode trap and CSR unit (mstatus/mie/mip/mtvec/mepc/mcause)
// Arbitrates interrupt > exception > MRET > CSR write for the EX-stage instruction.
module trap_csr_unit #(
  parameter int              XLEN       = 32,
  parameter int              NUM_IRQ    = 4,
  parameter logic [XLEN-1:0] TVEC_RESET = 'h0000_0100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               ex_valid,
  input  logic [XLEN-1:0]    ex_pc,
  input  logic               ex_exc,
  input  logic [7:0]         ex_exc_code,
  input  logic               ex_mret,
  input  logic [1:0]         csr_op,
  input  logic [11:0]        csr_addr,
  input  logic [XLEN-1:0]    csr_wdata,
  output logic [XLEN-1:0]    csr_rdata,
  output logic               redirect,
  output logic [XLEN-1:0]    redirect_pc,
  output logic [NUM_IRQ-1:0] irq_pending
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  logic [NUM_IRQ-1:0] sync1_q, sync1_d;
  logic [NUM_IRQ-1:0] sync2_q, sync2_d;
  logic               mstatus_mie_q, mstatus_mie_d;
  logic               mpie_q, mpie_d;
  logic [NUM_IRQ-1:0] mie_q, mie_d;
  logic [XLEN-1:2]    mtvec_base_q, mtvec_base_d;
  logic               mtvec_mode_q, mtvec_mode_d;
  logic [XLEN-1:2]    mepc_q, mepc_d;
  logic               mcause_int_q, mcause_int_d;
  logic [7:0]         mcause_code_q, mcause_code_d;

  logic [NUM_IRQ-1:0] pend;
  logic [3:0]         irq_idx;
  logic               irq_take, exc_take, mret_take, csr_we;
  logic [XLEN-1:0]    csr_new;

  // Lowest-index pending line wins, so scan downward and let the last hit stick.
  always_comb begin
    pend    = sync2_q & mie_q;
    irq_idx = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) irq_idx = 4'(i);
    end
  end

  assign irq_pending = pend;
  assign irq_take    = ex_valid & mstatus_mie_q & (|pend);
  assign exc_take    = ex_valid & ~irq_take & ex_exc;
  assign mret_take   = ex_valid & ~irq_take & ~ex_exc & ex_mret;
  assign csr_we      = ex_valid & ~irq_take & ~ex_exc & ~ex_mret & (csr_op != 2'b00)
                     & ((csr_op == OP_RW) | (|csr_wdata));

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      ADDR_MSTATUS: csr_rdata = {{(XLEN-8){1'b0}}, mpie_q, 3'b000, mstatus_mie_q, 3'b000};
      ADDR_MIE:     csr_rdata = {{(XLEN-NUM_IRQ){1'b0}}, mie_q};
      ADDR_MIP:     csr_rdata = {{(XLEN-NUM_IRQ){1'b0}}, sync2_q};
      ADDR_MTVEC:   csr_rdata = {mtvec_base_q, 1'b0, mtvec_mode_q};
      ADDR_MEPC:    csr_rdata = {mepc_q, 2'b00};
      ADDR_MCAUSE:  csr_rdata = {mcause_int_q, {(XLEN-9){1'b0}}, mcause_code_q};
      default:      csr_rdata = '0;
    endcase
  end

  always_comb begin
    case (csr_op)
      OP_RW:   csr_new = csr_wdata;
      OP_RS:   csr_new = csr_rdata | csr_wdata;
      OP_RC:   csr_new = csr_rdata & ~csr_wdata;
      default: csr_new = csr_rdata;
    endcase
  end

  always_comb begin
    redirect    = irq_take | exc_take | mret_take;
    redirect_pc = {mtvec_base_q, 2'b00};
    if (mret_take) begin
      redirect_pc = {mepc_q, 2'b00};
    end else if (irq_take && mtvec_mode_q) begin
      redirect_pc = {mtvec_base_q, 2'b00} + {{(XLEN-6){1'b0}}, irq_idx, 2'b00};
    end
  end

  always_comb begin
    sync1_d       = irq_in;
    sync2_d       = sync1_q;
    mstatus_mie_d = mstatus_mie_q;
    mpie_d        = mpie_q;
    mie_d         = mie_q;
    mtvec_base_d  = mtvec_base_q;
    mtvec_mode_d  = mtvec_mode_q;
    mepc_d        = mepc_q;
    mcause_int_d  = mcause_int_q;
    mcause_code_d = mcause_code_q;
    if (irq_take || exc_take) begin
      mepc_d        = ex_pc[XLEN-1:2];
      mcause_int_d  = irq_take;
      mcause_code_d = irq_take ? {4'b0000, irq_idx} : ex_exc_code;
      mpie_d        = mstatus_mie_q;
      mstatus_mie_d = 1'b0;
    end else if (mret_take) begin
      mstatus_mie_d = mpie_q;
      mpie_d        = 1'b1;
    end else if (csr_we) begin
      // Read-only and unimplemented bits are dropped after the RW/RS/RC op.
      case (csr_addr)
        ADDR_MSTATUS: begin
          mstatus_mie_d = csr_new[3];
          mpie_d        = csr_new[7];
        end
        ADDR_MIE:    mie_d = csr_new[NUM_IRQ-1:0];
        ADDR_MTVEC: begin
          mtvec_base_d = csr_new[XLEN-1:2];
          mtvec_mode_d = csr_new[0];
        end
        ADDR_MEPC:   mepc_d = csr_new[XLEN-1:2];
        ADDR_MCAUSE: begin
          mcause_int_d  = csr_new[XLEN-1];
          mcause_code_d = csr_new[7:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      mstatus_mie_q <= 1'b0;
      mpie_q        <= 1'b0;
      mie_q         <= '0;
      mtvec_base_q  <= TVEC_RESET[XLEN-1:2];
      mtvec_mode_q  <= TVEC_RESET[0];
      mepc_q        <= '0;
      mcause_int_q  <= 1'b0;
      mcause_code_q <= '0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      mstatus_mie_q <= mstatus_mie_d;
      mpie_q        <= mpie_d;
      mie_q         <= mie_d;
      mtvec_base_q  <= mtvec_base_d;
      mtvec_mode_q  <= mtvec_mode_d;
      mepc_q        <= mepc_d;
      mcause_int_q  <= mcause_int_d;
      mcause_code_q <= mcause_code_d;
    end
  end

endmodule
